// File: rtl/reg_display_ctrl.sv
// Register display sequencer: redraws changed R0..R7 rows as 8x8 hex glyphs, one pixel per clock.
// Define REGDISP_LABEL_EN to also draw the register index glyph to the left of each value.

module char_bitmap (
    input  logic [7:0]  code,
    output logic [63:0] pixel_line
);
    // Row r occupies pixel_line[r*8 +: 8], bit 7 of each byte is the leftmost pixel.
    function automatic logic [63:0] pack(
        input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] r2, input logic [7:0] r3,
        input logic [7:0] r4, input logic [7:0] r5, input logic [7:0] r6, input logic [7:0] r7
    );
        return {r7, r6, r5, r4, r3, r2, r1, r0};
    endfunction

    always_comb begin
        case (code)
            8'h00:   pixel_line = pack(8'h3C, 8'h66, 8'h6E, 8'h76, 8'h66, 8'h66, 8'h3C, 8'h00);
            8'h01:   pixel_line = pack(8'h18, 8'h38, 8'h18, 8'h18, 8'h18, 8'h18, 8'h7E, 8'h00);
            8'h02:   pixel_line = pack(8'h3C, 8'h66, 8'h06, 8'h0C, 8'h30, 8'h60, 8'h7E, 8'h00);
            8'h03:   pixel_line = pack(8'h3C, 8'h66, 8'h06, 8'h1C, 8'h06, 8'h66, 8'h3C, 8'h00);
            8'h04:   pixel_line = pack(8'h0C, 8'h1C, 8'h3C, 8'h6C, 8'hFE, 8'h0C, 8'h0C, 8'h00);
            8'h05:   pixel_line = pack(8'h00, 8'hFE, 8'hC0, 8'hFC, 8'h06, 8'hC6, 8'h7C, 8'h00);
            8'h06:   pixel_line = pack(8'h3C, 8'h60, 8'hC0, 8'hFC, 8'hC6, 8'hC6, 8'h7C, 8'h00);
            8'h07:   pixel_line = pack(8'hFE, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h30, 8'h30, 8'h00);
            8'h08:   pixel_line = pack(8'h7C, 8'hC6, 8'hC6, 8'h7C, 8'hC6, 8'hC6, 8'h7C, 8'h00);
            8'h09:   pixel_line = pack(8'h7C, 8'hC6, 8'hC6, 8'h7E, 8'h06, 8'h0C, 8'h78, 8'h00);
            8'h0A:   pixel_line = pack(8'h38, 8'h6C, 8'hC6, 8'hC6, 8'hFE, 8'hC6, 8'hC6, 8'h00);
            8'h0B:   pixel_line = pack(8'hFC, 8'h66, 8'h66, 8'h7C, 8'h66, 8'h66, 8'hFC, 8'h00);
            8'h0C:   pixel_line = pack(8'h3C, 8'h66, 8'hC0, 8'hC0, 8'hC0, 8'h66, 8'h3C, 8'h00);
            8'h0D:   pixel_line = pack(8'hF8, 8'h6C, 8'h66, 8'h66, 8'h66, 8'h6C, 8'hF8, 8'h00);
            8'h0E:   pixel_line = pack(8'hFE, 8'h62, 8'h68, 8'h78, 8'h68, 8'h62, 8'hFE, 8'h00);
            8'h0F:   pixel_line = pack(8'hFE, 8'h62, 8'h68, 8'h78, 8'h68, 8'h60, 8'hF0, 8'h00);
            default: pixel_line = '0;
        endcase
    end
endmodule

module reg_display_ctrl #(
    parameter int         X_LABEL     = 40,
    parameter int         X_VALUE     = 104,
    parameter int         Y_START     = 40,
    parameter int         ROW_PITCH   = 12,
    parameter logic [8:0] LABEL_COLOR = 9'b000111000,
    parameter logic [8:0] DATA_COLOR  = 9'b111000000,
    parameter logic [8:0] BACK_COLOR  = 9'b000000000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [3:0] R0,
    input  logic [3:0] R1,
    input  logic [3:0] R2,
    input  logic [3:0] R3,
    input  logic [3:0] R4,
    input  logic [3:0] R5,
    input  logic [3:0] R6,
    input  logic [3:0] R7,
    input  logic       refresh,
    output logic [9:0] x,
    output logic [8:0] y,
    output logic [8:0] color,
    output logic       write,
    output logic       busy
);
    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_LOAD     = 2'd1;
    localparam logic [1:0] S_DRAW_LBL = 2'd2;
    localparam logic [1:0] S_DRAW_VAL = 2'd3;

    logic [1:0]  state_reg;
    logic [2:0]  sel_reg;
    logic [3:0]  snap_reg;
    logic [5:0]  cnt_reg;
    logic [2:0]  rr_ptr_reg;
    logic [7:0]  dirty_reg;
    logic [7:0]  dirty_next;
    logic [3:0]  shadow_reg [8];
    logic [3:0]  r_vals [8];
    logic [7:0]  mismatch;
    logic [7:0]  pending;
    logic [7:0]  clear_mask;
    logic [2:0]  pick_idx;
    logic [2:0]  cand;
    logic        pick_found;
    logic        in_label;
    logic [7:0]  glyph_code;
    logic [63:0] pixel_line;
    logic [2:0]  row;
    logic [2:0]  col;
    logic        pix_bit;
    logic [9:0]  x_base;
    logic [8:0]  fg_color;

    assign r_vals[0] = R0;
    assign r_vals[1] = R1;
    assign r_vals[2] = R2;
    assign r_vals[3] = R3;
    assign r_vals[4] = R4;
    assign r_vals[5] = R5;
    assign r_vals[6] = R6;
    assign r_vals[7] = R7;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_cmp
            assign mismatch[gi] = (r_vals[gi] != shadow_reg[gi]);
        end
    endgenerate

    // Comparing against the shadow directly lets IDLE react in the same cycle a value changes.
    assign pending    = dirty_reg | mismatch | {8{refresh}};
    assign clear_mask = (state_reg == S_LOAD) ? (8'b1 << sel_reg) : 8'b0;
    assign dirty_next = ((dirty_reg | mismatch) & ~clear_mask) | {8{refresh}};

    always_comb begin
        pick_idx   = rr_ptr_reg;
        pick_found = 1'b0;
        cand       = '0;
        for (int k = 0; k < 8; k++) begin
            cand = rr_ptr_reg + 3'(k);
            if (!pick_found && pending[cand]) begin
                pick_idx   = cand;
                pick_found = 1'b1;
            end
        end
    end

    assign in_label   = (state_reg == S_DRAW_LBL);
    assign glyph_code = in_label ? {5'b0, sel_reg} : {4'b0, snap_reg};
    assign row        = cnt_reg[5:3];
    assign col        = cnt_reg[2:0];
    assign pix_bit    = pixel_line[{row, ~col}];
    assign x_base     = in_label ? 10'(X_LABEL) : 10'(X_VALUE);
    assign fg_color   = in_label ? LABEL_COLOR : DATA_COLOR;
    assign busy       = (state_reg != S_IDLE);

    char_bitmap u_char_bitmap (
        .code       (glyph_code),
        .pixel_line (pixel_line)
    );

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_reg  <= S_IDLE;
            sel_reg    <= '0;
            snap_reg   <= '0;
            cnt_reg    <= '0;
            rr_ptr_reg <= '0;
            dirty_reg  <= 8'hFF;
            x          <= '0;
            y          <= '0;
            color      <= '0;
            write      <= 1'b0;
            for (int k = 0; k < 8; k++) begin
                shadow_reg[k] <= '0;
            end
        end else begin
            dirty_reg <= dirty_next;
            write     <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (|pending) begin
                        sel_reg   <= pick_idx;
                        state_reg <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    snap_reg            <= r_vals[sel_reg];
                    shadow_reg[sel_reg] <= r_vals[sel_reg];
                    rr_ptr_reg          <= sel_reg + 3'd1;
                    cnt_reg             <= '0;
`ifdef REGDISP_LABEL_EN
                    state_reg           <= S_DRAW_LBL;
`else
                    state_reg           <= S_DRAW_VAL;
`endif
                end
                default: begin
                    // Both draw phases share the same 64-pixel raster walk.
                    x       <= x_base + 10'(col);
                    y       <= 9'(Y_START) + 9'(sel_reg) * 9'(ROW_PITCH) + 9'(row);
                    color   <= pix_bit ? fg_color : BACK_COLOR;
                    write   <= 1'b1;
                    cnt_reg <= cnt_reg + 6'd1;
                    if (cnt_reg == 6'd63) begin
                        state_reg <= in_label ? S_DRAW_VAL : S_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_reg_display_ctrl.sv
// Scoreboard bench for reg_display_ctrl: expected pixel streams are queued by the stimulus
// and a negedge monitor pops one entry per observed write.
`timescale 1ns/1ps
module tb_reg_display_ctrl;
`ifdef REGDISP_LABEL_EN
    localparam int LBL = 1;
`else
    localparam int LBL = 0;
`endif
    localparam int ROW_WRITES = 64 * (LBL + 1);
    localparam logic [8:0] LABEL_C = 9'b000111000;
    localparam logic [8:0] DATA_C  = 9'b111000000;
    localparam logic [8:0] BACK_C  = 9'b000000000;

    typedef struct {
        int  px;
        int  py;
        int  pc;
        bit  last;
    } pix_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       refresh = 1'b0;
    logic [3:0] r [8];
    logic [9:0] x;
    logic [8:0] y;
    logic [8:0] color;
    logic       write;
    logic       busy;

    pix_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   total_writes = 0;
    int   seen_color = -1;

    always #10 clk = ~clk;

    reg_display_ctrl dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .R0       (r[0]),
        .R1       (r[1]),
        .R2       (r[2]),
        .R3       (r[3]),
        .R4       (r[4]),
        .R5       (r[5]),
        .R6       (r[6]),
        .R7       (r[7]),
        .refresh  (refresh),
        .x        (x),
        .y        (y),
        .color    (color),
        .write    (write),
        .busy     (busy)
    );

    // Glyph rows packed with row 0 in the most significant byte.
    function automatic logic [7:0] glyph_row(input int code, input int rw);
        logic [63:0] g;
        case (code)
            0:  g = 64'h3C666E7666663C00;
            1:  g = 64'h1838181818187E00;
            2:  g = 64'h3C66060C30607E00;
            3:  g = 64'h3C66061C06663C00;
            4:  g = 64'h0C1C3C6CFE0C0C00;
            5:  g = 64'h00FEC0FC06C67C00;
            6:  g = 64'h3C60C0FCC6C67C00;
            7:  g = 64'hFE060C1830303000;
            8:  g = 64'h7CC6C67CC6C67C00;
            9:  g = 64'h7CC6C67E060C7800;
            10: g = 64'h386CC6C6FEC6C600;
            11: g = 64'hFC66667C6666FC00;
            12: g = 64'h3C66C0C0C0663C00;
            13: g = 64'hF86C6666666CF800;
            14: g = 64'hFE6268786862FE00;
            default: g = 64'hFE6268786860F000;
        endcase
        return g[63 - 8 * rw -: 8];
    endfunction

    task automatic push_glyph(input int xb, input int yb, input int code, input logic [8:0] fg);
        logic [7:0] bits;
        pix_t p;
        for (int rw = 0; rw < 8; rw++) begin
            bits = glyph_row(code, rw);
            for (int cl = 0; cl < 8; cl++) begin
                p.px = xb + cl;
                p.py = yb + rw;
                p.pc = bits[7 - cl] ? int'(fg) : int'(BACK_C);
                p.last = (rw == 7 && cl == 7);
                exp_q.push_back(p);
            end
        end
    endtask

    task automatic push_row(input int idx, input int val);
        if (LBL != 0) push_glyph(40, 40 + 12 * idx, idx, LABEL_C);
        push_glyph(104, 40 + 12 * idx, val, DATA_C);
    endtask

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        repeat (4) tick();
        while (!(busy === 1'b0 && write === 1'b0) && n < 3000) begin
            tick();
            n++;
        end
        check({name, "_timeout"}, (n < 3000) ? 0 : 1, 0);
        check({name, "_drained"}, exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        pix_t e;
        if (write === 1'b1) begin
            total_writes++;
            if (x == 10'd106 && y == 9'd65) seen_color = int'(color);
            checks++;
            if (x < 10'd40 || x > 10'd111 || y < 9'd40 || y > 9'd131) begin
                failures++;
                $display("FAIL pixel_range: got x=%0d y=%0d expected x 40..111 y 40..131", x, y);
            end
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write: got x=%0d y=%0d color=%0d expected no write", x, y, color);
            end else begin
                e = exp_q.pop_front();
                if (int'(x) != e.px || int'(y) != e.py || int'(color) != e.pc) begin
                    failures++;
                    $display("FAIL pixel: got x=%0d y=%0d color=%0d expected x=%0d y=%0d color=%0d",
                             x, y, color, e.px, e.py, e.pc);
                end else if (e.last) begin
                    $display("glyph done: last pixel x=%0d y=%0d", x, y);
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        int lat;
        int n;
        int g;
        for (int i = 0; i < 8; i++) r[i] = 4'd0;
        reset = 1'b1;
        repeat (3) tick();
        check("reset_write", int'(write), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_x", int'(x), 0);
        check("reset_y", int'(y), 0);
        check("reset_color", int'(color), 0);

        // Full redraw after reset
        for (int i = 0; i < 8; i++) push_row(i, 0);
        w0 = total_writes;
        reset = 1'b0;
        wait_idle("init");
        check("init_writes", total_writes - w0, 8 * ROW_WRITES);

        // R2 0->5: latency and one known pixel
        seen_color = -1;
        push_row(2, 5);
        w0 = total_writes;
        r[2] = 4'd5;
        lat = 0;
        while (lat < 10) begin
            tick();
            lat++;
            if (write === 1'b1) break;
        end
        check("r2_latency", lat, 3);
        check("r2_first_x", int'(x), (LBL != 0) ? 40 : 104);
        check("r2_first_y", int'(y), 64);
        wait_idle("r2");
        check("r2_writes", total_writes - w0, ROW_WRITES);
        check("pix_106_65", seen_color, int'(DATA_C));

        // R6 and R1 together with rr_ptr=3: R6 first
        push_row(6, 10);
        push_row(1, 7);
        r[6] = 4'd10;
        r[1] = 4'd7;
        wait_idle("r6_r1");

        // rr_ptr now 2: R3 must precede R0
        push_row(3, 12);
        push_row(0, 15);
        r[0] = 4'd15;
        r[3] = 4'd12;
        wait_idle("r3_r0");

        // R4 changes 3->9 in the middle of its value glyph
        push_row(4, 3);
        w0 = total_writes;
        r[4] = 4'd3;
        n = 0;
        g = 0;
        while (n < 64 * LBL + 10 && g < 300) begin
            tick();
            g++;
            if (write === 1'b1) n++;
        end
        check("r4_reached_mid", n, 64 * LBL + 10);
        r[4] = 4'd9;
        push_row(4, 9);
        wait_idle("r4");
        check("r4_writes", total_writes - w0, 2 * ROW_WRITES);

        // Refresh while idle, rr_ptr=5
        for (int k = 0; k < 8; k++) push_row((5 + k) % 8, int'(r[(5 + k) % 8]));
        w0 = total_writes;
        refresh = 1'b1;
        tick();
        refresh = 1'b0;
        wait_idle("refresh");
        check("refresh_writes", total_writes - w0, 8 * ROW_WRITES);

        // Reset at write #40 of R0
        reset = 1'b1;
        tick();
        tick();
        exp_q.delete();
        for (int i = 0; i < 8; i++) push_row(i, int'(r[i]));
        reset = 1'b0;
        n = 0;
        g = 0;
        while (n < 40 && g < 200) begin
            tick();
            g++;
            if (write === 1'b1) n++;
        end
        check("mid_reset_reached", n, 40);
        reset = 1'b1;
        tick();
        check("mid_reset_write", int'(write), 0);
        check("mid_reset_x", int'(x), 0);
        check("mid_reset_y", int'(y), 0);
        check("mid_reset_color", int'(color), 0);
        check("mid_reset_busy", int'(busy), 0);
        exp_q.delete();
        for (int i = 0; i < 8; i++) push_row(i, int'(r[i]));
        tick();
        reset = 1'b0;
        wait_idle("mid_reset_redraw");

        // Quiet period: any write here is unexpected
        repeat (50) tick();
        check("quiet_busy", int'(busy), 0);
        check("quiet_queue", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
